// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the pipeline hazard scoreboard:
//   - default geometry (read/write ports, address width, PC register, mc width)
//   - forward-select codes driven onto the E-stage operand muxes
//   - helpers that size the packed tag words kept per pipeline stage
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEF_NREAD  = 4;
  localparam int DEF_NWRITE = 2;
  localparam int DEF_AW     = 4;
  localparam int DEF_PC_REG = 15;
  localparam int DEF_MCW    = 3;

  localparam int FWD_W = 3;

  localparam logic [FWD_W-1:0] FWD_RF    = 3'd0;  // register file value
  localparam logic [FWD_W-1:0] FWD_RESW  = 3'd1;  // ResultW
  localparam logic [FWD_W-1:0] FWD_ALUM  = 3'd2;  // ALUOutM
  localparam logic [FWD_W-1:0] FWD_ALU2M = 3'd3;  // ALUOut2M
  localparam logic [FWD_W-1:0] FWD_RES2W = 3'd4;  // Result2W

  // E tag layout (LSB first): ra, ra_used, wa, we, is_load, valid
  function automatic int tag_e_width(input int nread, input int nwrite, input int aw);
    return nread * aw + nread + nwrite * aw + nwrite + 2;
  endfunction

  // M/W tag layout (LSB first): wa, we, is_load, valid
  function automatic int tag_mw_width(input int nwrite, input int aw);
    return nwrite * aw + nwrite + 2;
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// ---------------------------------------------------------------------------
// hazard_tag_stage
// One pipeline tag register. Loads i_d when i_en is high, or zero (a bubble)
// when i_en and i_clr are both high; holds otherwise.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-high reset (clears the tag)
//   i_en   in  1   update enable
//   i_clr  in  1   load a bubble instead of i_d
//   i_d    in  W   next tag value
//   o_q    out W   registered tag
// ---------------------------------------------------------------------------
module hazard_tag_stage
  import hazard_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Tag register: bubble on clear, load on enable, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_q <= '0;
      end else begin
        r_q <= i_d;
      end
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Forwarding / interlock controller for a 5-stage F/D/E/M/W pipeline with
// NREAD read ports and NWRITE write ports per instruction, load-use interlock
// and multi-cycle Execute operations. Destination tags are tracked through
// E, M and W internally; all control outputs are combinational from those
// tags and the Decode-stage inputs.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   d_valid             instruction present in Decode
//   d_ra / d_ra_used    Decode read addresses (port i at [i*AW+:AW]) / enables
//   d_wa / d_we         Decode write addresses / enables
//   d_is_load           write port 0 result comes from memory (end of M)
//   d_mc_extra          extra Execute cycles for this op (0 = single cycle)
//   branch_taken_e      branch resolved taken in Execute
//   fwd_e               per E read port forward select (hazard_pkg FWD_* codes)
//   stall_f / stall_d   hold PC / F-D register
//   flush_d / flush_e   clear F-D register / bubble into D-E register
//   e_busy              Execute holding a multi-cycle op
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE,
  parameter int AW     = DEF_AW,
  parameter int PC_REG = DEF_PC_REG,
  parameter int MCW    = DEF_MCW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [NREAD*AW-1:0]     d_ra,
  input  logic [NREAD-1:0]        d_ra_used,
  input  logic [NWRITE*AW-1:0]    d_wa,
  input  logic [NWRITE-1:0]       d_we,
  input  logic                    d_is_load,
  input  logic [MCW-1:0]          d_mc_extra,
  input  logic                    branch_taken_e,
  output logic [NREAD*FWD_W-1:0]  fwd_e,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic                    e_busy
);

  localparam int TW_E    = tag_e_width(NREAD, NWRITE, AW);
  localparam int TW_MW   = tag_mw_width(NWRITE, AW);
  localparam int OFS_USE = NREAD * AW;
  localparam int OFS_WA  = OFS_USE + NREAD;
  localparam logic [AW-1:0]  PC_ADDR = AW'(PC_REG);
  localparam logic [MCW-1:0] MC_ONE  = MCW'(1);

  logic [TW_E-1:0]          w_d_tag;
  logic [TW_E-1:0]          w_e_tag;
  logic [TW_MW-1:0]         w_m_tag;
  logic [TW_MW-1:0]         w_w_tag;

  logic [NREAD*AW-1:0]      w_e_ra;
  logic [NREAD-1:0]         w_e_used;
  logic [NWRITE*AW-1:0]     w_e_wa;
  logic [NWRITE-1:0]        w_e_we;
  logic                     w_e_ld;
  logic                     w_e_valid;
  logic [NWRITE*AW-1:0]     w_m_wa;
  logic [NWRITE-1:0]        w_m_we;
  logic [NWRITE*AW-1:0]     w_w_wa;
  logic [NWRITE-1:0]        w_w_we;

  logic [MCW-1:0]           r_mc_cnt;
  logic                     w_busy;
  logic [NREAD-1:0]         w_d_hit;
  logic                     w_lu;
  logic                     w_stall;
  logic                     w_flush_d;
  logic                     w_flush_e;
  logic                     w_e_capture;
  logic [NREAD*FWD_W-1:0]   w_fwd;
  logic                     w_unused;

  // Layout here must match tag_e_width(): {valid, is_load, we, wa, ra_used, ra}
  assign w_d_tag = {1'b1, d_is_load, d_we, d_wa, d_ra_used, d_ra};

  // Execute tag holds while a multi-cycle op is running
  hazard_tag_stage #(.W(TW_E)) u_tag_e (
    .clk   (clk),
    .reset (reset),
    .i_en  (!w_busy),
    .i_clr (w_flush_e || !d_valid),
    .i_d   (w_d_tag),
    .o_q   (w_e_tag)
  );

  // M receives a bubble on every cycle the op stays in E
  hazard_tag_stage #(.W(TW_MW)) u_tag_m (
    .clk   (clk),
    .reset (reset),
    .i_en  (1'b1),
    .i_clr (w_busy),
    .i_d   (w_e_tag[TW_E-1:OFS_WA]),
    .o_q   (w_m_tag)
  );

  hazard_tag_stage #(.W(TW_MW)) u_tag_w (
    .clk   (clk),
    .reset (reset),
    .i_en  (1'b1),
    .i_clr (1'b0),
    .i_d   (w_m_tag),
    .o_q   (w_w_tag)
  );

  assign w_e_ra    = w_e_tag[OFS_USE-1:0];
  assign w_e_used  = w_e_tag[OFS_WA-1:OFS_USE];
  assign w_e_wa    = w_e_tag[OFS_WA +: NWRITE*AW];
  assign w_e_we    = w_e_tag[OFS_WA + NWRITE*AW +: NWRITE];
  assign w_e_ld    = w_e_tag[TW_E-2];
  assign w_e_valid = w_e_tag[TW_E-1];
  assign w_m_wa    = w_m_tag[NWRITE*AW-1:0];
  assign w_m_we    = w_m_tag[NWRITE*AW +: NWRITE];
  assign w_w_wa    = w_w_tag[NWRITE*AW-1:0];
  assign w_w_we    = w_w_tag[NWRITE*AW +: NWRITE];

  // is_load/valid ride along in M/W for debug visibility; only port 0 of E
  // participates in the load-use check.
  assign w_unused = ^{w_m_tag[TW_MW-1 -: 2], w_w_tag[TW_MW-1 -: 2],
                      w_e_wa[NWRITE*AW-1:AW], w_e_we[NWRITE-1:1]};

  assign w_busy = (r_mc_cnt != '0);

  // Multi-cycle counter: loaded when a real op enters E, counts down to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mc_cnt <= '0;
    end else if (w_busy) begin
      r_mc_cnt <= r_mc_cnt - MC_ONE;
    end else if (w_e_capture) begin
      r_mc_cnt <= d_mc_extra;
    end else begin
      r_mc_cnt <= '0;
    end
  end

  assign w_e_capture = d_valid && !w_flush_e;

  // Forward select per E read port. Codes are defined for two write ports;
  // port 0 is checked first so a doubled destination resolves to port 0.
  for (genvar i = 0; i < NREAD; i++) begin : g_fwd
    logic [AW-1:0]      w_ra;
    logic [NWRITE-1:0]  w_m_hit;
    logic [NWRITE-1:0]  w_w_hit;
    logic [FWD_W-1:0]   w_sel;

    assign w_ra = w_e_ra[i*AW +: AW];

    for (genvar j = 0; j < NWRITE; j++) begin : g_wr
      assign w_m_hit[j] = w_m_we[j] && (w_m_wa[j*AW +: AW] == w_ra);
      assign w_w_hit[j] = w_w_we[j] && (w_w_wa[j*AW +: AW] == w_ra);
    end

    // Priority: youngest producer (M) first, port 0 before port 1
    always_comb begin
      w_sel = FWD_RF;
      if (w_e_used[i] && (w_ra != PC_ADDR)) begin
        if (w_m_hit[0]) begin
          w_sel = FWD_ALUM;
        end else if (w_m_hit[1]) begin
          w_sel = FWD_ALU2M;
        end else if (w_w_hit[0]) begin
          w_sel = FWD_RESW;
        end else if (w_w_hit[1]) begin
          w_sel = FWD_RES2W;
        end else begin
          w_sel = FWD_RF;
        end
      end else begin
        w_sel = FWD_RF;
      end
    end

    assign w_fwd[i*FWD_W +: FWD_W] = w_sel;
  end

  // A Decode read of the register a load in E is still fetching
  for (genvar i = 0; i < NREAD; i++) begin : g_lu
    assign w_d_hit[i] = d_ra_used[i] &&
                        (d_ra[i*AW +: AW] != PC_ADDR) &&
                        (d_ra[i*AW +: AW] == w_e_wa[AW-1:0]);
  end

  assign w_lu = w_e_valid && w_e_ld && w_e_we[0] && (|w_d_hit);

  // Stall/flush: a taken branch overrides both interlocks; a busy E never
  // inserts a bubble because the op itself stays there.
  always_comb begin
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_stall   = 1'b0;
    if (branch_taken_e) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_stall   = 1'b0;
    end else if (w_busy) begin
      w_stall   = 1'b1;
    end else if (w_lu) begin
      w_stall   = 1'b1;
      w_flush_e = 1'b1;
    end else begin
      w_stall   = 1'b0;
    end
  end

  // Gating with reset keeps every output low while reset is held, even if
  // branch_taken_e is asserted by upstream logic at that time.
  assign fwd_e   = reset ? '0   : w_fwd;
  assign stall_f = !reset && w_stall;
  assign stall_d = !reset && w_stall;
  assign flush_d = !reset && w_flush_d;
  assign flush_e = !reset && w_flush_e;
  assign e_busy  = !reset && w_busy;

endmodule
